// File: rtl/pmod_serial_subtractor_pkg.sv
// Shared types and arithmetic for the PMOD bit-serial subtractor.
// Holds the FSM state enum, synchronizer depth and the one-bit full subtractor.
package pmod_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int SYNC_STAGES = 2;

  // Returns {bout, d} for d = a - b - bin.
  function automatic logic [1:0] fs_bit(input logic a, input logic b, input logic bin);
    logic d;
    logic bout;
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
    return {bout, d};
  endfunction

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/pmod_serial_subtractor_if.sv
// Pin bundle of the serial subtractor: PMOD inputs, LED outputs and debug state.
// Handshake: no valid/ready; each synchronized PMOD3 rise carries one {PMOD1, PMOD2} bit pair.
interface pmod_serial_subtractor_if #(
  parameter int WIDTH = 2
);
  localparam int CW = pmod_arith_pkg::cnt_width(WIDTH);

  logic             PMOD1;
  logic             PMOD2;
  logic             PMOD3;
  logic             PMOD4;
  logic [WIDTH-1:0] DIFF;
  logic             BORROW;
  logic             DONE;
  logic             BUSY;

  pmod_arith_pkg::sub_state_t state;
  logic [CW-1:0]              bit_cnt;

  modport slave (
    input  PMOD1, PMOD2, PMOD3, PMOD4,
    output DIFF, BORROW, DONE, BUSY, state, bit_cnt
  );

  modport master (
    output PMOD1, PMOD2, PMOD3, PMOD4,
    input  DIFF, BORROW, DONE, BUSY, state, bit_cnt
  );

endinterface

// File: rtl/pmod_serial_subtractor_input_conditioner.sv
// Control-pin conditioner: 2-FF synchronizer, optional debounce (PMOD_DEBOUNCE_EN),
// then either the level (EDGE=0) or a registered one-cycle rise pulse (EDGE=1).
module pmod_input_conditioner
  import pmod_arith_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter bit EDGE            = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic ev
);

`ifdef PMOD_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   filtered;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  generate
    if (DB_EN) begin : g_debounce
      localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
      logic [DCW-1:0] cnt_q;
      logic           stable_q;

      // A new level is adopted only after DEBOUNCE_CYCLES consecutive differing samples.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q    <= '0;
          stable_q <= 1'b0;
        end else if (synced == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DCW'(DEBOUNCE_CYCLES - 1)) begin
          stable_q <= synced;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      assign filtered = stable_q;
    end else begin : g_raw
      assign filtered = synced;
    end

    if (EDGE) begin : g_edge
      logic prev_q;
      logic rise_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_q <= 1'b0;
          rise_q <= 1'b0;
        end else begin
          prev_q <= filtered;
          rise_q <= filtered & ~prev_q;
        end
      end
      assign ev = rise_q;
    end else begin : g_level
      assign ev = filtered;
    end
  endgenerate

endmodule

// File: rtl/pmod_serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit pair per PMOD3 rise; PMOD4 clears.
// Optional PMOD_DEBOUNCE_EN debounces the strobe and clear pins.
module pmod_serial_subtractor
  import pmod_arith_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  pmod_serial_subtractor_if.slave    bus
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic strobe;
  logic clear;

  pmod_input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .EDGE(1'b1)) u_strobe (
    .clk(CLK), .rst_n(RST_N), .pin(bus.PMOD3), .ev(strobe)
  );

  pmod_input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .EDGE(1'b0)) u_clear (
    .clk(CLK), .rst_n(RST_N), .pin(bus.PMOD4), .ev(clear)
  );

  logic [SYNC_STAGES-1:0] a_sync_q;
  logic [SYNC_STAGES-1:0] b_sync_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], bus.PMOD1};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], bus.PMOD2};
    end
  end

  sub_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] diff_q;
  logic             final_borrow_q;

  logic             take;
  logic             finish;
  logic             bin;
  logic [1:0]       fs;
  logic [WIDTH-1:0] shift_next;

  assign take = strobe & ~clear;
  assign bin  = (state_q == SHIFT) & borrow_q;
  assign fs   = fs_bit(a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1], bin);

  // New difference bit enters at the MSB so bit i lands at position i after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign shift_next = fs[0];
    end else begin : g_wn
      assign shift_next = {fs[0], shreg_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else if (take) begin
      case (state_q)
        IDLE, DONE: begin
          if (WIDTH == 1) begin
            state_d = DONE;
            finish  = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
            finish  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q          <= '0;
      borrow_q       <= 1'b0;
      shreg_q        <= '0;
      diff_q         <= '0;
      final_borrow_q <= 1'b0;
    end else if (clear) begin
      cnt_q          <= '0;
      borrow_q       <= 1'b0;
      shreg_q        <= '0;
      diff_q         <= '0;
      final_borrow_q <= 1'b0;
    end else if (take) begin
      shreg_q  <= shift_next;
      borrow_q <= fs[1];
      if (finish) begin
        diff_q         <= shift_next;
        final_borrow_q <= fs[1];
        cnt_q          <= '0;
      end else if (state_q == SHIFT) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= CW'(1);
      end
    end
  end

  assign bus.DIFF    = diff_q;
  assign bus.BORROW  = final_borrow_q;
  assign bus.DONE    = (state_q == DONE);
  assign bus.BUSY    = (state_q == SHIFT);
  assign bus.state   = state_q;
  assign bus.bit_cnt = cnt_q;

endmodule

// File: doc/pmod_serial_subtractor.md
Name: pmod_serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor for the iCEstick-class board. It computes A - B from operands entered by hand, one bit pair at a time and LSB first, on PMOD pins.
- Each bit pair is clocked in by a strobe pin. The difference, final borrow and status drive LEDs through the board top.
- It is the inverse-operation companion of the combinational PMOD adder. Unlike the adder, it is sequential: operands arrive over time and the result is latched.

Parameters:
- WIDTH, 2, operand and difference width in bits (legal range 1..16).
- DEBOUNCE_CYCLES, 12000, number of stable CLK cycles a strobe or clear level must hold. Used only when PMOD_DEBOUNCE_EN is defined; 12000 is 1 ms at 12 MHz.

Ports:
- CLK  input  1  system clock (12 MHz on the board).
- RST_N  input  1  asynchronous, active-low reset.
- PMOD1  input  1  minuend bit A[i]; asynchronous pin.
- PMOD2  input  1  subtrahend bit B[i]; asynchronous pin.
- PMOD3  input  1  bit strobe; each rising edge consumes one bit pair; asynchronous pin.
- PMOD4  input  1  clear; level-sensitive, active-high, synchronized.
- DIFF  output  WIDTH  latched difference (A - B) mod 2^WIDTH; mapped to LED1/LED2 at WIDTH=2.
- BORROW  output  1  latched final borrow, i.e. A < B unsigned (LED3).
- DONE  output  1  result valid (LED4).
- BUSY  output  1  operation in progress (LED5).

Behaviour:
- Reset and interface:
  - One clock domain. Reset is asynchronous and active-low (RST_N).
  - On RST_N low, all outputs are 0 immediately, the FSM is in IDLE, and the bit counter, borrow flip-flop, shift register and synchronizers are cleared.
- Input conditioning:
  - PMOD1..PMOD4 pass through 2-FF synchronizers.
  - The strobe event is a rising edge of the synchronized PMOD3, detected against its previous registered value.
  - A and B are sampled from their synchronized values in the same cycle as the strobe event.
- Per-bit arithmetic, a full subtractor with borrow-in bin:
  - d = A ^ B ^ bin
  - bout = (~A & B) | (~(A ^ B) & bin)
  - bin is 0 for bit 0.
  - d shifts into the shift register from the MSB side, so after WIDTH bits, register bit i holds d_i.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: BUSY=0, DONE=0. A strobe event consumes bit 0. The FSM goes to SHIFT if WIDTH>1, or to DONE if WIDTH=1.
  - SHIFT: BUSY=1. Each strobe event consumes the next bit. The event carrying bit WIDTH-1 transfers the shift result to DIFF and the final bout to BORROW, then moves to DONE.
  - DONE: DONE=1, BUSY=0. DIFF and BORROW are held. A strobe event starts a new operation with that pair as bit 0 (DONE drops, same transitions as IDLE); DIFF and BORROW hold their old values until the new result completes.
- Output update rule: DIFF and BORROW change only on completion, clear or reset.
- Latency: DONE rises on the 4th CLK rising edge after the final PMOD3 rising edge, counted from the first edge that samples it high (2 synchronizer stages, 1 edge detect, 1 state register). Without debounce this is exact.
- Clear (synchronized PMOD4 = 1):
  - From any state, next state is IDLE, and DIFF, BORROW, counter and borrow are zeroed.
  - Clear has priority over a simultaneous strobe event; that bit is dropped.
  - While clear is held, strobe events are ignored.
- Wrap-around: the counter runs 0..WIDTH-1 and never exceeds it. Extra strobes while in DONE always begin a new operation.
- Async reset mid-SHIFT: the partial operand is discarded with no residual state.

Optional Feature:
- Macro: PMOD_DEBOUNCE_EN.
- Defined: each synchronized PMOD3/PMOD4 level is accepted only after it has been stable for DEBOUNCE_CYCLES consecutive cycles. The strobe edge and the clear act on the debounced level. Latency increases by DEBOUNCE_CYCLES. A and B are still sampled at the debounced strobe event.
- Undefined: synchronizer plus edge detect only; the DEBOUNCE_CYCLES parameter is ignored.

Decomposition:
- Package pmod_arith_pkg:
  - state enum sub_state_t {IDLE, SHIFT, DONE};
  - SYNC_STAGES = 2;
  - full-subtractor function fs_bit(a, b, bin) returning {bout, d}.
- Sub-module pmod_input_conditioner:
  - one instance per control pin: 2-FF synchronizer, optional debounce (PMOD_DEBOUNCE_EN), rise-pulse output;
  - data pins use the synchronizer only.

Test Plan:
- 3 - 1 with WIDTH=2: strobe bit pairs (1,1) then (1,0) -> DIFF=2'b10, BORROW=0, DONE=1, exactly 4 CLK after the 2nd strobe edge (no debounce).
- 1 - 2: pairs (1,0) then (0,1) -> DIFF=2'b11, BORROW=1; 0 - 0 -> DIFF=0, BORROW=0, DONE=1.
- Clear after 1 of 2 bits: FSM returns to IDLE, BUSY=0, DIFF=0. Then run 2 - 1 -> DIFF=1, with no leftover bit or borrow.
- Strobe edge and clear high in the same synchronized cycle -> bit ignored, IDLE, counter=0. Also: RST_N low mid-SHIFT -> all outputs 0 immediately (asynchronously).
- Back-to-back from DONE (3 - 1 then 0 - 3): DIFF stays 2 until the 2nd result completes, then DIFF=1, BORROW=1. DONE is low during the second operation.
- With PMOD_DEBOUNCE_EN and DEBOUNCE_CYCLES=8: a 5-cycle glitch on PMOD3 consumes no bit; a 10-cycle pulse consumes exactly one bit.
